// File: rtl/mdu.sv
// mdu: multiply/divide unit holding the HI/LO registers.
// Operands come straight from the register file read ports. An operation
// captures its 64-bit result at launch and writes it to HI/LO after a fixed
// busy period. The busy period stands in for a multi-cycle datapath.
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   A, B            operands (rs, rt)
//   start, op       launch strobe; 0=MULT 1=MULTU 2=DIV 3=DIVU
//   mthi, mtlo      write A into HI / LO while idle
//   busy            an operation is in flight
//   occupied        combinational start | busy, used by decode to stall
//   hi, lo          HI/LO register contents
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      temp_hi_q, temp_hi_d;
  logic [31:0]      temp_lo_q, temp_lo_d;
  logic             div_zero_q, div_zero_d;

  // Datapath: one 64-bit multiply and one unsigned divide on magnitudes.
  logic        is_div, sgn;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] dvd, dvs, uq, ur, quo, rem;
  logic        neg_q, neg_r;

  always_comb begin
    is_div = op[1];
    sgn    = (op == OP_MULT) || (op == OP_DIV);

    // Sign extension makes the low 64 bits of the product correct for
    // both signed and unsigned operands.
    mul_a = {{32{A[31] & sgn}}, A};
    mul_b = {{32{B[31] & sgn}}, B};
    prod  = mul_a * mul_b;

    // Signed divide on magnitudes; 0x80000000 negates to itself and is
    // still the correct unsigned magnitude, so MIN/-1 needs no special case.
    neg_r = sgn && A[31];
    neg_q = sgn && (A[31] ^ B[31]);
    dvd   = neg_r ? 32'(-A) : A;
    dvs   = (sgn && B[31]) ? 32'(-B) : B;
    if (dvs == 32'd0) begin
      dvs = 32'd1;  // result is discarded on divide-by-zero
    end
    uq  = dvd / dvs;
    ur  = dvd % dvs;
    quo = neg_q ? 32'(-uq) : uq;
    rem = neg_r ? 32'(-ur) : ur;
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    temp_hi_d  = temp_hi_q;
    temp_lo_d  = temp_lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_BUSY;
          cnt_d      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          temp_hi_d  = is_div ? rem : prod[63:32];
          temp_lo_d  = is_div ? quo : prod[31:0];
          div_zero_d = is_div && (B == 32'd0);
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!div_zero_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      temp_hi_q  <= '0;
      temp_lo_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      temp_hi_q  <= temp_hi_d;
      temp_lo_q  <= temp_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign occupied = start | busy;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, occupied;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .start(start), .op(op),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .occupied(occupied),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural model: an accepted operation schedules its result for a
  // known edge number; nothing is accepted until that edge has passed.
  longint      edge_no = 0;
  longint      done_edge = 0;
  logic        m_active = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_ok = 1'b0;
  logic        m_valid = 1'b0;

  task automatic model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output logic ok);
    longint sa, sb, sq, sr, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    ok = 1'b1; rh = '0; rl = '0;
    case (o)
      2'd0: begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
      2'd1: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
      2'd2: if (b == 0) ok = 1'b0;
            else begin sq = sa / sb; sr = sa % sb; rh = sr[31:0]; rl = sq[31:0]; end
      default: if (b == 0) ok = 1'b0;
            else begin up = ua / ub; rh = 32'(ua % ub); rl = up[31:0]; end
    endcase
  endtask

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_active = 1'b0; m_valid = 1'b1;
    end else if (m_active) begin
      if (edge_no == done_edge) begin
        if (p_ok) begin m_hi = p_hi; m_lo = p_lo; end
        m_active = 1'b0;
      end
    end else if (start) begin
      model_result(op, A, B, p_hi, p_lo, p_ok);
      done_edge = edge_no + longint'(op[1] ? DC : MC);
      m_active = 1'b1;
    end else begin
      if (mthi) m_hi = A;
      if (mtlo) m_lo = A;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_active));
      check("occupied", 32'(occupied), 32'(start | m_active));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic drive(input logic s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic mh, input logic ml);
    @(posedge clk); #1;
    start = s; op = o; A = a; B = b; mthi = mh; mtlo = ml;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Counts busy cycles after launch; stops at the first idle negedge.
  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input int n);
    drive(1'b1, o, a, b, 1'b0, 1'b0);
    idle();
    wait_done(name, n);
  endtask

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 32'h0); check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0); check("rst_occ", 32'(occupied), 32'd0);

    // 2: multiply
    run_op(2'd0, 32'hFFFFFFFE, 32'd3, "mult_cycles", MC);
    check("mult_hi", hi, 32'hFFFFFFFF); check("mult_lo", lo, 32'hFFFFFFFA);
    run_op(2'd1, 32'hFFFFFFFE, 32'd3, "multu_cycles", MC);
    check("multu_hi", hi, 32'h00000002); check("multu_lo", lo, 32'hFFFFFFFA);

    // 3: divide
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, "div_cycles", DC);
    check("div_lo", lo, 32'hFFFFFFFD); check("div_hi", hi, 32'hFFFFFFFF);
    run_op(2'd3, 32'd7, 32'd2, "divu_cycles", DC);
    check("divu_lo", lo, 32'd3); check("divu_hi", hi, 32'd1);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "ovf_cycles", DC);
    check("ovf_lo", lo, 32'h80000000); check("ovf_hi", hi, 32'h0);
    run_op(2'd2, 32'd7, 32'hFFFFFFFE, "div_negb_cycles", DC);
    check("div_negb_lo", lo, 32'hFFFFFFFD); check("div_negb_hi", hi, 32'd1);

    // 4: mthi/mtlo then divide by zero
    drive(1'b0, 2'd0, 32'h11, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 32'h22, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 2'd2, 32'd5, 32'd0, 1'b0, 1'b0);
    #1 check("dz_occ", 32'(occupied), 32'd1);
    check("dz_pre_hi", hi, 32'h11); check("dz_pre_lo", lo, 32'h22);
    idle();
    wait_done("dz_cycles", DC);
    check("dz_hi", hi, 32'h11); check("dz_lo", lo, 32'h22);

    // start + mt in idle: start wins
    drive(1'b1, 2'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    idle();
    wait_done("startwin_cycles", MC);
    check("startwin_hi", hi, 32'd0); check("startwin_lo", lo, 32'd12);

    // 5: requests during busy are ignored
    drive(1'b1, 2'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    idle();
    drive(1'b1, 2'd1, 32'h99, 32'd2, 1'b0, 1'b1);
    idle();
    wait_done("ign_cycles", MC - 2);
    check("ign_hi", hi, 32'd0); check("ign_lo", lo, 32'd42);
    @(negedge clk);
    check("ign_not_ext", 32'(busy), 32'd0);

    // 6: reset mid-operation
    drive(1'b0, 2'd0, 32'd5, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 2'd3, 32'd100, 32'd3, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_hi", hi, 32'd5);
    idle();
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0); check("abort_lo", lo, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("late_hi", hi, 32'd0); check("late_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
